// File: rtl/mix_columns_iter.sv
// Column-serial AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Mixes COLS_PER_CYCLE columns per clock; the mode bit is latched with each block.
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1,
   parameter int word_size      = 8,
   parameter int array_size     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            inverse,
   input  logic [word_size*array_size-1:0] state,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [word_size*array_size-1:0] state_out,
   output logic                            busy
);

   localparam int STATE_W = word_size * array_size;
   localparam int COL_W   = 4 * word_size;
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end
   if (word_size != 8 || array_size != 16) begin : g_bad_size
      $error("mix_columns_iter: word_size must be 8 and array_size must be 16");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   fsm_t                   fsm_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic [1:0]             col_cnt_q;
   logic                   inv_q;
   logic [STATE_W-1:0]     in_q;
   logic [STATE_W-1:0]     state_out_q;
   logic [COL_W-1:0]       col_mix_d [COLS_PER_CYCLE];

   function automatic logic [word_size-1:0] xtime(input logic [word_size-1:0] b);
      return {b[word_size-2:0], 1'b0} ^ (b[word_size-1] ? 8'h1b : 8'h00);
   endfunction

   // Coefficients never exceed 0x0e, so four xtime steps cover every product.
   function automatic logic [word_size-1:0] gf_mul(input logic [word_size-1:0] a,
                                                   input logic [3:0] c);
      logic [word_size-1:0] p;
      logic [word_size-1:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
      logic [word_size-1:0] s [4];
      logic [3:0]           m [4];
      logic [word_size-1:0] o;
      logic [COL_W-1:0]     r;
      for (int k = 0; k < 4; k++) s[k] = col[COL_W-1-word_size*k -: word_size];
      if (inv) begin
         m[0] = 4'he; m[1] = 4'hb; m[2] = 4'hd; m[3] = 4'h9;
      end else begin
         m[0] = 4'h2; m[1] = 4'h3; m[2] = 4'h1; m[3] = 4'h1;
      end
      r = '0;
      for (int row = 0; row < 4; row++) begin
         o = '0;
         for (int k = 0; k < 4; k++) o = o ^ gf_mul(s[(row + k) % 4], m[k]);
         r[COL_W-1-word_size*row -: word_size] = o;
      end
      return r;
   endfunction

   always_comb begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_mix_d[j] = mix_col(in_q[STATE_W-1-COL_W*int'(col_cnt_q + 2'(j)) -: COL_W], inv_q);
      end
   end

   // The captured block is only read while BUSY, so it needs no reset.
   always_ff @(posedge clk) begin
      if (fsm_q == IDLE && in_valid) in_q <= state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         col_cnt_q   <= '0;
         inv_q       <= 1'b0;
         state_out_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  fsm_q      <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  inv_q      <= inverse;
                  col_cnt_q  <= '0;
               end
            end
            BUSY: begin
               for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                  state_out_q[STATE_W-1-COL_W*int'(col_cnt_q + 2'(j)) -: COL_W] <= col_mix_d[j];
               end
               col_cnt_q <= col_cnt_q + STEP;
               if (col_cnt_q == LAST_GRP) begin
                  fsm_q       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm_q       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               fsm_q      <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign state_out = state_out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: one instance per legal COLS_PER_CYCLE (1, 2, 4),
// checked against a polynomial-arithmetic MixColumns reference.
module tb_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         inverse   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic         busy      [3];
   logic [127:0] st_in     [3];
   logic [127:0] st_out    [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .inverse   (inverse[g]),
         .state     (st_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .state_out (st_out[g]),
         .busy      (busy[g])
      );
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Carry-less product followed by long division by 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
      logic [7:0]   fr [4];
      logic [7:0]   ir [4];
      logic [7:0]   o;
      logic [7:0]   coef;
      logic [127:0] r;
      fr = '{8'h02, 8'h03, 8'h01, 8'h01};
      ir = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      r  = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            o = '0;
            for (int k = 0; k < 4; k++) begin
               coef = inv ? ir[(k - row + 4) % 4] : fr[(k - row + 4) % 4];
               o = o ^ gmul(coef, s[127 - 8*(4*c + k) -: 8]);
            end
            r[127 - 8*(4*c + row) -: 8] = o;
         end
      end
      return r;
   endfunction

   // Offer one block to unit u and wait for out_valid; leaves the unit in DONE.
   task automatic send(input int u, input logic [127:0] s, input logic inv, input bit scramble,
                       output logic [127:0] res);
      int n;
      int lat;
      n   = 4 >> u;
      lat = 0;
      while (!in_ready[u] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!in_ready[u]) check("in_ready_wait", 128'(in_ready[u]), 128'(1));
      in_valid[u] = 1'b1;
      st_in[u]    = s;
      inverse[u]  = inv;
      @(negedge clk);
      in_valid[u] = 1'b0;
      check("busy_high", 128'(busy[u]), 128'(1));
      lat = 0;
      while (!out_valid[u] && lat < 50) begin
         if (scramble) begin
            st_in[u]    = {$urandom, $urandom, $urandom, $urandom};
            inverse[u]  = ~inverse[u];
            in_valid[u] = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      in_valid[u] = 1'b0;
      check("latency", 128'(lat), 128'(n));
      check("in_ready_done", 128'(in_ready[u]), 128'(0));
      check("busy_done", 128'(busy[u]), 128'(0));
      res = st_out[u];
   endtask

   task automatic release_out(input int u);
      out_ready[u] = 1'b1;
      @(negedge clk);
      out_ready[u] = 1'b0;
      check("out_valid_drop", 128'(out_valid[u]), 128'(0));
      check("in_ready_back", 128'(in_ready[u]), 128'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] s;
      logic [127:0] s2;
      logic [127:0] res;
      logic [127:0] exp;
      logic         inv;
      logic         inv2;

      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         in_valid[u] = 1'b0; inverse[u] = 1'b0; out_ready[u] = 1'b0; st_in[u] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 3; u++) begin
         check("rst_in_ready", 128'(in_ready[u]), 128'(1));
         check("rst_out_valid", 128'(out_valid[u]), 128'(0));
         check("rst_busy", 128'(busy[u]), 128'(0));
         check("rst_state_out", st_out[u], 128'(0));
      end

      // Known-answer vectors
      send(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0, res);
      check("kat_fwd_c1", res, 128'h046681e5e0cb199a48f8d37a2806264c);
      release_out(0);
      send(2, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0, res);
      check("kat_inv_c4", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      release_out(2);
      send(1, 128'hdb135345f20a225c01010101d4d4d4d5, 1'b0, 1'b0, res);
      check("kat_cols_c2", res, 128'h8e4da1bc9fdc589d01010101d5d5d7d6);
      release_out(1);

      // Back-pressure, with a pending input that must wait for IDLE
      s   = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_mix(s, 1'b0);
      send(1, s, 1'b0, 1'b0, res);
      s2   = {$urandom, $urandom, $urandom, $urandom};
      inv2 = 1'b1;
      in_valid[1] = 1'b1;
      st_in[1]    = s2;
      inverse[1]  = inv2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid[1]), 128'(1));
         check("bp_state_out", st_out[1], exp);
         check("bp_in_ready", 128'(in_ready[1]), 128'(0));
      end
      out_ready[1] = 1'b1;
      @(negedge clk);
      out_ready[1] = 1'b0;
      check("bp_release_valid", 128'(out_valid[1]), 128'(0));
      check("bp_release_ready", 128'(in_ready[1]), 128'(1));
      send(1, s2, inv2, 1'b0, res);
      check("bp_second_block", res, ref_mix(s2, inv2));
      release_out(1);

      // Asynchronous reset in the second BUSY cycle
      in_valid[0] = 1'b1;
      st_in[0]    = {$urandom, $urandom, $urandom, $urandom};
      inverse[0]  = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(out_valid[0]), 128'(0));
      check("arst_state_out", st_out[0], 128'(0));
      check("arst_in_ready", 128'(in_ready[0]), 128'(1));
      check("arst_busy", 128'(busy[0]), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      s = {$urandom, $urandom, $urandom, $urandom};
      send(0, s, 1'b1, 1'b0, res);
      check("arst_next_block", res, ref_mix(s, 1'b1));
      release_out(0);

      // Inputs churn during BUSY; the captured block and mode must win
      for (int u = 0; u < 2; u++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         send(u, s, 1'b1, 1'b1, res);
         check("mode_isolation", res, ref_mix(s, 1'b1));
         release_out(u);
      end

      // Random blocks on every width
      for (int u = 0; u < 3; u++) begin
         for (int i = 0; i < 6; i++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            send(u, s, inv, 1'b0, res);
            check("random_block", res, ref_mix(s, inv));
            release_out(u);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Parametrised, handshaked AES MixColumns / InvMixColumns engine for the round datapath. It accepts one 128-bit state and processes it column-serially, COLS_PER_CYCLE columns per clock. It returns the mixed state with a valid/ready handshake. The mode bit, captured per block, selects the forward (encrypt) or inverse (decrypt) matrix, so one instance serves both cipher directions.

## Interface
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; any other value must fail elaboration.
- word_size, 8, byte width; fixed at 8.
- array_size, 16, bytes per state; fixed at 16.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block.
- inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with the block.
- state  in  128  input state; byte b = state[127-8b -: 8], column c = bytes 4c..4c+3, row r = byte 4c+r.
- out_valid  out  1  state_out holds a finished block.
- out_ready  in  1  consumer accepts state_out.
- state_out  out  128  mixed state, same byte layout as state.
- busy  out  1  high while in BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, capture state into the input register, latch inverse, clear col_cnt, and go to BUSY.
- BUSY: each cycle, mix columns col_cnt..col_cnt+COLS_PER_CYCLE-1 and write them into the matching slices of state_out. Add COLS_PER_CYCLE to col_cnt. After the group containing column 3 is written, go to DONE.
- DONE: out_valid=1 and state_out is stable. On out_ready, go to IDLE.
- in_ready=1 only in IDLE. in_valid is ignored in BUSY and DONE, and the upstream must hold it.
- Forward matrix rows: (02 03 01 01), (01 02 03 01), (01 01 02 03), (03 01 01 02).
- Inverse matrix rows: (0e 0b 0d 09), (09 0e 0b 0d), (0d 09 0e 0b), (0b 0d 09 0e).
- Output byte r of a column = XOR over k of M[r][k]·s[k].
- All multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11b). Implement it as xtime chains, with each product reduced to 8 bits.
- No intermediate value is wider than 8 bits. There is no deferred modular reduction.
- col_cnt is 2 bits and wraps only at a new block.
- Changes to state or inverse after capture do not affect a block in flight.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, state_out=0, col_cnt=0, latched mode=0.
- Asserting rst in any state, including mid-BUSY, returns the block to these values asynchronously. Any partial block is discarded.
- Acceptance edge is E0. BUSY lasts N = 4/COLS_PER_CYCLE cycles. out_valid rises after edge E0+N.
- Latency from acceptance to out_valid is N cycles.
- Minimum block period is N+2 cycles: N in BUSY, one cycle in DONE with out_ready=1, one cycle in IDLE.
- Back-pressure: with out_ready=0, the block stays in DONE indefinitely, holding state_out and out_valid.
- in_valid and out_ready high together in DONE: only the output transfer completes. The input is accepted in the following IDLE cycle.
- Columns not yet processed in BUSY keep their previous value in state_out. Consumers must sample only while out_valid=1.

## Test plan
- Forward, COLS_PER_CYCLE=1: state = d4bf5d30e0b452aeb84111f11e2798e5, inverse=0 -> state_out = 046681e5e0cb199a48f8d37a2806264c. out_valid rises 4 cycles after acceptance.
- Inverse, COLS_PER_CYCLE=4: state = 046681e5e0cb199a48f8d37a2806264c, inverse=1 -> state_out = d4bf5d30e0b452aeb84111f11e2798e5. Latency is 1 cycle.
- Column vectors, COLS_PER_CYCLE=2, forward: state = db135345 f20a225c 01010101 d4d4d4d5 -> state_out = 8e4da1bc 9fdc589d 01010101 d5d5d7d6. Latency is 2 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out are stable and in_ready=0. Raise out_ready -> IDLE next cycle, and a second block is accepted and computed correctly.
- Reset mid-operation: assert rst during the 2nd BUSY cycle (COLS_PER_CYCLE=1) -> immediately out_valid=0, state_out=0, in_ready=1. A subsequent block gives the correct result.
- Mode isolation: accept a block with inverse=1, then toggle inverse and state every cycle during BUSY -> result equals InvMixColumns of the captured state.
